// File: rtl/ddr_port_arbiter3.sv
// ddr_port_arbiter3: shares one DDR valid/ready port between CPU (P0),
// VerilogBoy master (P1) and video line fetcher (P2). Round-robin, one
// transaction in flight, per-port base remap, BUSY watchdog.
// Optional build macro: ARB_VIDEO_PRIORITY_EN (P2 always wins in IDLE).
module ddr_port_arbiter3 #(
  parameter logic [23:0] P0_BASE = 24'h000000,
  parameter logic [23:0] P1_BASE = 24'h800000,
  parameter logic [23:0] P2_BASE = 24'h000000,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic        clkrv,
  input  logic        rst,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  input  logic        p0_valid,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  input  logic        p1_valid,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  input  logic [23:0] p2_addr,
  input  logic [31:0] p2_wdata,
  input  logic [3:0]  p2_wstrb,
  input  logic        p2_valid,
  output logic [31:0] p2_rdata,
  output logic        p2_ready,
  output logic [23:0] ddr_addr,
  output logic [31:0] ddr_wdata,
  output logic [3:0]  ddr_wstrb,
  output logic        ddr_valid,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_ready,
  output logic        timeout_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBusy    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]  state_q, grant_q, rr_ptr_q, rr_next;
  logic [15:0] cnt_q;
  logic        ddr_valid_q, timeout_err_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [2:0]  req;
  logic [2:0]  sum;
  logic [1:0]  idx, win;
  logic        win_found;
  logic [23:0] sel_addr, sel_base;
  logic [31:0] sel_wdata, done_rdata;
  logic [3:0]  sel_wstrb;
  logic        busy, tmo_hit, done;

  assign req = {p2_valid, p1_valid, p0_valid};

  // Winner: first requesting port at or after rr_ptr, cyclic over 0,1,2.
  always_comb begin
    win_found = 1'b0;
    win       = 2'd0;
    sum       = 3'd0;
    idx       = 2'd0;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, rr_ptr_q} + 3'(i);
      if (sum >= 3'd3) sum = sum - 3'd3;
      idx = sum[1:0];
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
`ifdef ARB_VIDEO_PRIORITY_EN
    if (p2_valid) begin
      win_found = 1'b1;
      win       = 2'd2;
    end
`endif
  end

  // Request fields of the selected port.
  always_comb begin
    sel_addr  = p2_addr;
    sel_wdata = p2_wdata;
    sel_wstrb = p2_wstrb;
    sel_base  = P2_BASE;
    unique case (win)
      2'd0: begin
        sel_addr = p0_addr; sel_wdata = p0_wdata; sel_wstrb = p0_wstrb; sel_base = P0_BASE;
      end
      2'd1: begin
        sel_addr = p1_addr; sel_wdata = p1_wdata; sel_wstrb = p1_wstrb; sel_base = P1_BASE;
      end
      default: ;
    endcase
  end

  // Completion (DDR ready or watchdog abort) and pointer advance.
  always_comb begin
    busy       = (state_q == StBusy);
    tmo_hit    = busy && !ddr_ready && (cnt_q == TIMEOUT);
    done       = busy && (ddr_ready || tmo_hit);
    done_rdata = ddr_ready ? ddr_rdata : 32'hDEADBEEF;
`ifdef ARB_VIDEO_PRIORITY_EN
    // P2 grants leave the P0/P1 pointer untouched.
    if (grant_q == 2'd2)      rr_next = rr_ptr_q;
    else if (grant_q == 2'd0) rr_next = 2'd1;
    else                      rr_next = 2'd0;
`else
    rr_next = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
`endif
  end

  // Per-port completion outputs; zero when not the completing grantee.
  always_comb begin
    p0_ready = done && (grant_q == 2'd0);
    p1_ready = done && (grant_q == 2'd1);
    p2_ready = done && (grant_q == 2'd2);
    p0_rdata = p0_ready ? done_rdata : 32'h0;
    p1_rdata = p1_ready ? done_rdata : 32'h0;
    p2_rdata = p2_ready ? done_rdata : 32'h0;
  end

  // Arbitration FSM and latched DDR request.
  always_ff @(posedge clkrv) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= 2'd0;
      rr_ptr_q      <= 2'd0;
      cnt_q         <= 16'd0;
      ddr_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      addr_q        <= 24'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found && !ddr_ready) begin
            grant_q     <= win;
            addr_q      <= (sel_addr & 24'hFFFFFC) | sel_base;
            wdata_q     <= sel_wdata;
            wstrb_q     <= sel_wstrb;
            ddr_valid_q <= 1'b1;
            cnt_q       <= 16'd0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (done) begin
            ddr_valid_q <= 1'b0;
            rr_ptr_q    <= rr_next;
            state_q     <= StRelease;
            if (tmo_hit) timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ddr_addr    = addr_q;
  assign ddr_wdata   = wdata_q;
  assign ddr_wstrb   = wstrb_q;
  assign ddr_valid   = ddr_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
